// File: rtl/barrel_shifter.sv
// Logarithmic left barrel shifter with a registered result.
//
// The shift amount is decoded one bit per stage: stage k moves the data left
// by 2^k positions when sel_i[k] is set and passes it through otherwise.
// Each stage fills the vacated LSBs with zeros, so the block is a logical
// shift, not a rotate. The last stage feeds the output register, which gives
// exactly one cycle of latency and no combinational path to dout_o.
//
// Ports:
//   clk_i   system clock, rising-edge active
//   rst_i   asynchronous, active-high reset; clears dout_o at once
//   din_i   data to be shifted (Width bits)
//   sel_i   unsigned shift amount, 0 .. Width-1 (SelW bits)
//   dout_o  registered (din_i << sel_i), truncated to Width bits
module barrel_shifter #(
  parameter int unsigned Width = 8,          // power of two, minimum 2
  parameter int unsigned SelW  = $clog2(Width)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] din_i,
  input  logic [SelW-1:0]  sel_i,
  output logic [Width-1:0] dout_o
);

  // stage[0] is the raw input; stage[SelW] is the fully shifted value.
  logic [Width-1:0] stage [SelW+1];
  logic [Width-1:0] dout_d;
  logic [Width-1:0] dout_q;

  assign stage[0] = din_i;

  for (genvar k = 0; k < SelW; k++) begin : g_stage
    // 2^k never exceeds Width/2, so the kept slice is always non-empty.
    localparam int unsigned Amt = 2 ** k;

    assign stage[k+1] = sel_i[k] ? {stage[k][Width-1-Amt:0], {Amt{1'b0}}} : stage[k];
  end

  assign dout_d = stage[SelW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed bench for barrel_shifter: reset behaviour, three SEL sweeps,
// back-to-back vectors and an asynchronous reset pulse between edges.
module tb_barrel_shifter;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [2:0] sel;
  logic [7:0] dout;

  int n_cmp = 0;
  int n_bad = 0;

  barrel_shifter #(
    .Width(8),
    .SelW (3)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .din_i (din),
    .sel_i (sel),
    .dout_o(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed sweep results, SEL = 0..7.
  logic [7:0] exp_0b [8] = '{8'b0000_1011, 8'b0001_0110, 8'b0010_1100, 8'b0101_1000,
                             8'b1011_0000, 8'b0110_0000, 8'b1100_0000, 8'b1000_0000};
  logic [7:0] exp_51 [8] = '{8'b0101_0001, 8'b1010_0010, 8'b0100_0100, 8'b1000_1000,
                             8'b0001_0000, 8'b0010_0000, 8'b0100_0000, 8'b1000_0000};
  logic [7:0] exp_ff [8] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  // Back-to-back vectors with hand-computed results.
  logic [7:0] b2b_din [6] = '{8'hA5, 8'h3C, 8'h81, 8'h00, 8'h7E, 8'hC3};
  logic [2:0] b2b_sel [6] = '{3'd1, 3'd2, 3'd7, 3'd5, 3'd3, 3'd4};
  logic [7:0] b2b_exp [6] = '{8'h4A, 8'hF0, 8'h80, 8'h00, 8'hF0, 8'h30};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: dout=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 ns later.
  task automatic step(input logic [7:0] d, input logic [2:0] s);
    din = d;
    sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted with live inputs and no edge yet: output must already be 0.
    rst = 1'b1;
    din = 8'hFF;
    sel = 3'd3;
    #2;
    check("reset_async", dout, 8'h00);
    rst = 1'b0;
    #1;
    check("reset_hold", dout, 8'h00);
    @(posedge clk);
    #1;
    check("reset_first_edge", dout, 8'b1111_1000);

    for (int i = 0; i < 8; i++) begin
      step(8'b0000_1011, 3'(i));
      check($sformatf("sweep_0b_sel%0d", i), dout, exp_0b[i]);
    end

    for (int i = 0; i < 8; i++) begin
      step(8'b0101_0001, 3'(i));
      check($sformatf("sweep_51_sel%0d", i), dout, exp_51[i]);
    end

    for (int i = 0; i < 8; i++) begin
      step(8'hFF, 3'(i));
      check($sformatf("sweep_ff_sel%0d", i), dout, exp_ff[i]);
    end

    for (int i = 0; i < 6; i++) begin
      step(b2b_din[i], b2b_sel[i]);
      check($sformatf("b2b_%0d", i), dout, b2b_exp[i]);
    end

    // Output must not follow inputs between edges.
    din = 8'h01;
    sel = 3'd0;
    #2;
    check("no_comb_path", dout, 8'h30);

    // Reset pulse between edges while holding 8'h58.
    step(8'b0000_1011, 3'd3);
    check("pre_reset_58", dout, 8'h58);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_async", dout, 8'h00);
    din = 8'h11;
    sel = 3'd2;
    rst = 1'b0;
    #1;
    check("mid_reset_hold", dout, 8'h00);
    @(posedge clk);
    #1;
    check("post_reset_load", dout, 8'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- 8-bit logarithmic barrel shifter with a registered output.
- Performs a logical left shift of DIN by the 0-7 bit amount on SEL, with zero fill.
- Used as a datapath utility block: the input is combinational through three mux stages, and the result is captured in an output register on each rising clock edge.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, minimum 2.
- SEL_W, 3, shift-amount width; equals log2(WIDTH).

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- DIN  input  WIDTH  data to be shifted.
- SEL  input  SEL_W  shift amount, unsigned, 0 to WIDTH-1.
- DOUT  output  WIDTH  registered shift result.

Behaviour:
- Function: DOUT_next = (DIN << SEL) truncated to WIDTH bits.
  - Bits shifted out of the MSB are discarded.
  - Vacated LSBs are filled with 0.
  - This is a logical shift, not a rotate.
- Structure: SEL_W cascaded 2:1 mux stages.
  - Stage k shifts left by 2^k when SEL[k]=1; otherwise it passes data through.
  - Stage 0 uses SEL[0], stage 1 uses SEL[1], and so on.
  - Each stage fills its vacated LSBs with zero.
  - The final stage output feeds the DOUT register.
- Latency: exactly 1 clock.
  - DOUT reflects the DIN/SEL values sampled at the most recent rising CLK edge.
  - There is no combinational path from DIN or SEL to DOUT.
- Throughput: one new operation per clock, with no stalls and no handshake.
  - DIN and SEL may change every cycle.
- Reset:
  - While RST=1, DOUT=0 immediately, without waiting for a clock edge.
  - DOUT stays 0 until the first rising CLK edge after RST deasserts.
  - That edge loads the shift of the DIN/SEL present at it.
- Reset mid-operation:
  - Asserting RST between edges clears DOUT at once.
  - The pending result is lost and is not replayed after reset.
- Boundary conditions:
  - SEL=0: DOUT=DIN (pass-through).
  - SEL=WIDTH-1: DOUT = {DIN[0], zeros}.
  - DIN all-zero always yields zero.
  - DIN all-ones with SEL=n yields ones in the upper WIDTH-n bits and zeros in the lower n.
- X/unknown on SEL is not required to be handled.
  - Inputs are defined during normal use.

Test Plan:
- Assert RST=1 with DIN=8'hFF, SEL=3 and no clock edge -> DOUT=8'h00 immediately. Deassert RST, apply one edge -> DOUT=8'b1111_1000.
- DIN=8'b0000_1011, sweep SEL 0..7 one value per clock -> DOUT one cycle later, in order:
  - 0000_1011, 0001_0110, 0010_1100, 0101_1000
  - 1011_0000, 0110_0000, 1100_0000, 1000_0000
- DIN=8'b0101_0001, sweep SEL 0..7 -> DOUT in order:
  - 0101_0001, 1010_0010, 0100_0100, 1000_1000
  - 0001_0000, 0010_0000, 0100_0000, 1000_0000
- DIN=8'b1111_1111, sweep SEL 0..7 -> DOUT in order:
  - FF, FE, FC, F8
  - F0, E0, C0, 80
  - Checks zero fill and distinguishes shift from rotate.
- Back-to-back changes: change DIN and SEL on every edge -> each DOUT matches the previous edge's inputs, with no bubbles.
- Reset pulse between edges while DOUT=8'h58 -> DOUT drops to 0 asynchronously. The next edge after release loads the current DIN<<SEL.
